bus_arbiter: RTL and testbench

- Shares the single CPU memory bus among four bus masters:
  - 0: IF-stage fetch
  - 1: MEM-stage data access, i.e. the address/as_/rw/wr_data outputs of the memory access controller
  - 2, 3: expansion masters such as DMA or a debug port
- Registered round-robin grant with active-low req_/grnt_ handshake.
- Muxes the owner's access signals onto the shared bus.
- A hold-timeout counter stops one master from monopolising the bus.

---
 rtl/bus_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_bus_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// bus_arbiter: shares the single CPU memory bus among four masters.
//   0 = IF-stage fetch, 1 = MEM-stage data access, 2/3 = expansion masters.
// Grant is a registered round-robin with an active-low req_/grnt_ handshake.
// A hold counter forcibly rotates ownership when one master keeps the bus
// for TIMEOUT consecutive cycles while another master is waiting.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-low reset
//   m_req_       per-master request, active low (bit i = master i)
//   m_grnt_      per-master grant, active low, one-hot-low or all high
//   m_addr       4 x 30-bit word address, master i at [30i+29:30i]
//   m_as_        per-master address strobe, active low
//   m_rw         per-master read/write (1 = READ, 0 = WRITE)
//   m_wr_data    4 x 32-bit write data, master i at [32i+31:32i]
//   s_addr       shared bus word address
//   s_as_        shared bus address strobe, active low
//   s_rw         shared bus read/write
//   s_wr_data    shared bus write data
//   owner        index of current owner, valid only while busy=1
//   busy         1 while any master holds a grant
//   timeout_err  one-cycle pulse when a forced revoke happens
module bus_arbiter #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [3:0]   m_req_,
  output logic [3:0]   m_grnt_,
  input  logic [119:0] m_addr,
  input  logic [3:0]   m_as_,
  input  logic [3:0]   m_rw,
  input  logic [127:0] m_wr_data,
  output logic [29:0]  s_addr,
  output logic         s_as_,
  output logic         s_rw,
  output logic [31:0]  s_wr_data,
  output logic [1:0]   owner,
  output logic         busy,
  output logic         timeout_err
);

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_r;
  logic [3:0]       grant_r;
  logic [1:0]       owner_r;
  logic [1:0]       last_r;
  logic [CNT_W-1:0] hold_cnt_r;
  logic             timeout_err_r;

  logic [3:0]       req_s;       // active-high copy of m_req_
  logic [3:0]       others_s;    // requesters other than the current owner
  logic [1:0]       idle_pick_s;
  logic [1:0]       pass_pick_s;

  // First set bit of want searching cyclically from (from+1); the final
  // step (k=4) wraps back onto from itself.
  function automatic logic [1:0] pick_next(input logic [3:0] want,
                                           input logic [1:0] from);
    logic [1:0] idx;
    logic [1:0] pick;
    pick = from;
    for (int k = 4; k >= 1; k--) begin
      idx = from + 2'(k);
      if (want[idx]) begin
        pick = idx;
      end else begin
        pick = pick;
      end
    end
    return pick;
  endfunction

  // Request decode and cyclic-search candidates for idle grant and handover.
  always_comb begin
    req_s       = ~m_req_;
    others_s    = req_s & ~(4'b0001 << owner_r);
    idle_pick_s = pick_next(req_s, last_r);
    pass_pick_s = pick_next(others_s, owner_r);
  end

  // Arbitration state: grant, owner, last-owner pointer, hold counter, error pulse.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r       <= IDLE;
      grant_r       <= 4'b1111;
      owner_r       <= 2'd0;
      last_r        <= 2'd3;
      hold_cnt_r    <= {CNT_W{1'b0}};
      timeout_err_r <= 1'b0;
    end else begin
      timeout_err_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (|req_s) begin
            state_r    <= OWNED;
            owner_r    <= idle_pick_s;
            grant_r    <= ~(4'b0001 << idle_pick_s);
            hold_cnt_r <= {CNT_W{1'b0}};
          end else begin
            grant_r <= 4'b1111;
          end
        end
        OWNED: begin
          if (req_s[owner_r]) begin
            // ">=" also catches a counter already saturated before a
            // competitor showed up, so the owner can never keep the bus
            // indefinitely once someone is waiting.
            if ((|others_s) && (hold_cnt_r >= CNT_LAST)) begin
              owner_r       <= pass_pick_s;
              grant_r       <= ~(4'b0001 << pass_pick_s);
              last_r        <= owner_r;
              hold_cnt_r    <= {CNT_W{1'b0}};
              timeout_err_r <= 1'b1;
            end else if (hold_cnt_r != CNT_MAX) begin
              hold_cnt_r <= hold_cnt_r + CNT_ONE;
            end else begin
              hold_cnt_r <= hold_cnt_r;
            end
          end else begin
            last_r <= owner_r;
            if (|others_s) begin
              // Direct handover, no idle gap.
              owner_r    <= pass_pick_s;
              grant_r    <= ~(4'b0001 << pass_pick_s);
              hold_cnt_r <= {CNT_W{1'b0}};
            end else begin
              state_r <= IDLE;
              grant_r <= 4'b1111;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          grant_r <= 4'b1111;
        end
      endcase
    end
  end

  // Shared-bus mux driven from the registered owner; idle bus is a disabled read.
  always_comb begin
    s_addr    = 30'd0;
    s_as_     = 1'b1;
    s_rw      = 1'b1;
    s_wr_data = 32'd0;
    if (state_r == OWNED) begin
      case (owner_r)
        2'd0: begin
          s_addr = m_addr[29:0];   s_as_ = m_as_[0]; s_rw = m_rw[0]; s_wr_data = m_wr_data[31:0];
        end
        2'd1: begin
          s_addr = m_addr[59:30];  s_as_ = m_as_[1]; s_rw = m_rw[1]; s_wr_data = m_wr_data[63:32];
        end
        2'd2: begin
          s_addr = m_addr[89:60];  s_as_ = m_as_[2]; s_rw = m_rw[2]; s_wr_data = m_wr_data[95:64];
        end
        2'd3: begin
          s_addr = m_addr[119:90]; s_as_ = m_as_[3]; s_rw = m_rw[3]; s_wr_data = m_wr_data[127:96];
        end
        default: begin
          s_addr = 30'd0; s_as_ = 1'b1; s_rw = 1'b1; s_wr_data = 32'd0;
        end
      endcase
    end else begin
      s_addr    = 30'd0;
      s_as_     = 1'b1;
      s_rw      = 1'b1;
      s_wr_data = 32'd0;
    end
  end

  assign m_grnt_     = grant_r;
  assign owner       = owner_r;
  assign busy        = (state_r == OWNED);
  assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;

  localparam int TO = 4;

  logic         clk;
  logic         reset;
  logic [3:0]   m_req_;
  logic [3:0]   m_grnt_;
  logic [119:0] m_addr;
  logic [3:0]   m_as_;
  logic [3:0]   m_rw;
  logic [127:0] m_wr_data;
  logic [29:0]  s_addr;
  logic         s_as_;
  logic         s_rw;
  logic [31:0]  s_wr_data;
  logic [1:0]   owner;
  logic         busy;
  logic         timeout_err;

  int n_checks = 0;
  int n_fail   = 0;

  bus_arbiter #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .m_req_(m_req_), .m_grnt_(m_grnt_),
    .m_addr(m_addr), .m_as_(m_as_), .m_rw(m_rw), .m_wr_data(m_wr_data),
    .s_addr(s_addr), .s_as_(s_as_), .s_rw(s_rw), .s_wr_data(s_wr_data),
    .owner(owner), .busy(busy), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // Owner is held while requesting, unless someone else waits and the owner
  // has already had TO cycles. Next owner = first requester after a start
  // index in cyclic order 0..3.
  bit       mvalid = 1'b0;
  bit       mb;
  int       mo, ml, mheld;
  bit       merr;
  bit [3:0] mwant, mothers;

  function automatic int first_after(input bit [3:0] want, input int start);
    for (int k = 1; k <= 4; k++)
      if (want[(start + k) % 4]) return (start + k) % 4;
    return start;
  endfunction

  always @(posedge clk) begin
    mwant = ~m_req_;
    if (!reset) begin
      mb = 1'b0; mo = 0; ml = 3; mheld = 0; merr = 1'b0; mvalid = 1'b1;
    end else if (mvalid) begin
      merr = 1'b0;
      if (!mb) begin
        if (mwant != 4'b0000) begin
          mo = first_after(mwant, ml); mb = 1'b1; mheld = 1;
        end
      end else begin
        mothers = mwant;
        mothers[mo] = 1'b0;
        if (mwant[mo] && (mothers == 4'b0000 || mheld < TO)) begin
          mheld++;
        end else begin
          if (mwant[mo]) merr = 1'b1;
          ml = mo;
          if (mothers != 4'b0000) begin
            mo = first_after(mothers, mo); mheld = 1;
          end else begin
            mb = 1'b0;
          end
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(posedge clk) begin
    #1;
    if (mvalid) begin
      check("model_busy", {31'd0, busy}, {31'd0, mb});
      check("model_grnt", {28'd0, m_grnt_}, mb ? {28'd0, ~(4'b0001 << mo)} : 32'h0000000f);
      check("model_terr", {31'd0, timeout_err}, {31'd0, merr});
      if (mb) begin
        check("model_owner", {30'd0, owner}, 32'(mo));
        check("model_saddr", {2'd0, s_addr}, {2'd0, m_addr[mo*30 +: 30]});
        check("model_sas", {31'd0, s_as_}, {31'd0, m_as_[mo]});
        check("model_srw", {31'd0, s_rw}, {31'd0, m_rw[mo]});
        check("model_swd", s_wr_data, m_wr_data[mo*32 +: 32]);
      end else begin
        check("model_idle_saddr", {2'd0, s_addr}, 32'd0);
        check("model_idle_sas", {31'd0, s_as_}, 32'd1);
        check("model_idle_srw", {31'd0, s_rw}, 32'd1);
        check("model_idle_swd", s_wr_data, 32'd0);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic rand_data();
    for (int i = 0; i < 4; i++) begin
      m_addr[i*30 +: 30]    = 30'($urandom);
      m_wr_data[i*32 +: 32] = $urandom;
    end
  endtask

  initial begin
    reset = 1'b0; m_req_ = 4'b1111; m_as_ = 4'b1111; m_rw = 4'b1111;
    rand_data();
    tick(); tick();
    check("reset_grnt", {28'd0, m_grnt_}, 32'h0000000f);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_owner", {30'd0, owner}, 32'd0);
    check("reset_terr", {31'd0, timeout_err}, 32'd0);
    reset = 1'b1;

    // Master 0 alone: one-cycle latency, its address passes through.
    m_addr[29:0] = 30'h0000100;
    m_as_ = 4'b1110;
    m_req_ = 4'b1110;
    tick();
    check("t1_grnt", {28'd0, m_grnt_}, 32'h0000000e);
    check("t1_busy", {31'd0, busy}, 32'd1);
    check("t1_owner", {30'd0, owner}, 32'd0);
    check("t1_saddr", {2'd0, s_addr}, 32'h00000100);
    check("t1_sas", {31'd0, s_as_}, 32'd0);
    tick(); tick();
    m_req_ = 4'b1111; m_as_ = 4'b1111;
    tick();
    check("t1_release", {28'd0, m_grnt_}, 32'h0000000f);

    // All request, each owner releases after 2 cycles: 0,1,2,3,0 back-to-back.
    reset = 1'b0; tick(); reset = 1'b1;
    m_req_ = 4'b0000;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("t2_owner", {30'd0, owner}, 32'(i % 4));
      check("t2_busy", {31'd0, busy}, 32'd1);
      tick();
      m_req_ = 4'b0001 << (i % 4);
      tick();
      check("t2_nogap", {31'd0, busy}, 32'd1);
      m_req_ = 4'b0000;
    end
    m_req_ = 4'b1111;
    tick();
    tick();

    // Master 1 releases then re-requests alone: exactly one idle cycle.
    m_req_ = 4'b1101;
    tick();
    check("t3_owner", {30'd0, owner}, 32'd1);
    tick();
    m_req_ = 4'b1111;
    tick();
    check("t3_idle_busy", {31'd0, busy}, 32'd0);
    check("t3_idle_sas", {31'd0, s_as_}, 32'd1);
    check("t3_idle_srw", {31'd0, s_rw}, 32'd1);
    m_req_ = 4'b1101;
    tick();
    check("t3_regrant", {28'd0, m_grnt_}, 32'h0000000d);
    m_req_ = 4'b1111;
    tick();

    // Master 2 holds, master 0 waits: forced rotate after 4 owned cycles.
    m_req_ = 4'b1011;
    tick();
    check("t4_owner2", {30'd0, owner}, 32'd2);
    m_req_ = 4'b1010;
    tick(); tick(); tick();
    check("t4_still2", {28'd0, m_grnt_}, 32'h0000000b);
    check("t4_noerr", {31'd0, timeout_err}, 32'd0);
    tick();
    check("t4_rotated", {28'd0, m_grnt_}, 32'h0000000e);
    check("t4_err", {31'd0, timeout_err}, 32'd1);
    tick();
    check("t4_err_pulse", {31'd0, timeout_err}, 32'd0);
    m_req_ = 4'b1111;
    tick();

    // Master 3 alone for 10 cycles: never revoked.
    m_req_ = 4'b0111;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t5_owner3", {28'd0, m_grnt_}, 32'h00000007);
      check("t5_noerr", {31'd0, timeout_err}, 32'd0);
    end
    m_req_ = 4'b1111;
    tick();

    // Reset during a master 1 write, then a 4-way tie goes to master 0.
    m_req_ = 4'b1101; m_rw = 4'b1101; m_as_ = 4'b1101;
    tick();
    check("t6_write_sas", {31'd0, s_as_}, 32'd0);
    check("t6_write_srw", {31'd0, s_rw}, 32'd0);
    check("t6_write_swd", s_wr_data, m_wr_data[63:32]);
    reset = 1'b0;
    tick();
    check("t6_rst_grnt", {28'd0, m_grnt_}, 32'h0000000f);
    check("t6_rst_sas", {31'd0, s_as_}, 32'd1);
    check("t6_rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b1; m_req_ = 4'b0000; m_rw = 4'b1111; m_as_ = 4'b1111;
    tick();
    check("t6_tie_owner", {30'd0, owner}, 32'd0);
    check("t6_tie_grnt", {28'd0, m_grnt_}, 32'h0000000e);
    m_req_ = 4'b1111;
    tick();

    // Randomized phase: sticky requests so both handovers and timeouts occur.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 5) == 0) m_req_[i] = ~m_req_[i];
      m_as_ = 4'($urandom);
      m_rw  = 4'($urandom);
      rand_data();
      reset = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
